// File: rtl/arq_tx_scheduler_if.sv
// Signal bundle between the ARQ frame scheduler and its mapper/transmitter neighbours.
// The master modport is the scheduler side. dbg_state mirrors the scheduler FSM state for checkers.
interface arq_tx_scheduler_if;
  // Handshake: the mapper holds i_frame_pending high until it sees the one-cycle o_frame_launch.
  // A launch only happens while i_enable and i_tx_idle are also high, so a pending frame is never dropped.
  // ACK/replay are transmitter events: i_tx_send_complete is a pulse and i_tx_read_line is a level
  // whose rising edges count as replays. o_tx_flush is a pulse that returns the transmitter to idle.
  logic        i_enable;
  logic        i_arq_en;
  logic        i_frame_pending;
  logic        o_frame_launch;
  logic        i_tx_idle;
  logic        i_tx_send_complete;
  logic        i_tx_read_line;
  logic        o_tx_flush;
  logic        o_busy;
  logic        o_frame_ok;
  logic        o_frame_fail;
  logic [1:0]  o_fail_cause;
  logic [3:0]  o_retry_count;
  logic [15:0] o_good_frames;
  logic [15:0] o_bad_frames;
  logic [2:0]  dbg_state;

  modport master (
    input  i_enable, i_arq_en, i_frame_pending, i_tx_idle, i_tx_send_complete, i_tx_read_line,
    output o_frame_launch, o_tx_flush, o_busy, o_frame_ok, o_frame_fail, o_fail_cause,
           o_retry_count, o_good_frames, o_bad_frames, dbg_state
  );

  modport slave (
    output i_enable, i_arq_en, i_frame_pending, i_tx_idle, i_tx_send_complete, i_tx_read_line,
    input  o_frame_launch, o_tx_flush, o_busy, o_frame_ok, o_frame_fail, o_fail_cause,
           o_retry_count, o_good_frames, o_bad_frames, dbg_state
  );
endinterface

// File: rtl/arq_tx_scheduler.sv
// Frame-level sequencer for the ARQ serial sender: launches frames, counts replays,
// enforces retry limit / ACK timeout, flushes the transmitter on failure, keeps frame statistics.
module arq_tx_scheduler #(
    parameter int MAX_RETRY       = 4,
    parameter int ACK_TIMEOUT_CYC = 2000000,
    parameter int GAP_CYC         = 16,
    parameter int TMR_W           = 24
) (
    input  logic                i_clk,
    input  logic                i_rst,
    arq_tx_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_START  = 3'd2,
        S_ACTIVE = 3'd3,
        S_OK     = 3'd4,
        S_FAIL   = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    localparam int GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
    localparam int GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gap_cnt;
    logic [3:0]         retry_count;
    logic [1:0]         fail_cause, cause_nxt;
    logic [15:0]        good_frames, bad_frames;
    logic               arq_mode;
    logic               rl_prev;
    logic               rl_edge, timeout, retry_at_max, gap_last;

    // Replay edges are only meaningful while a frame is in flight; a level already high on entry is ignored.
    assign rl_edge      = bus.i_tx_read_line & ~rl_prev & (state == S_ACTIVE);
    assign timeout      = (timer == TMR_W'(ACK_TIMEOUT_CYC - 1));
    assign retry_at_max = (retry_count == 4'(MAX_RETRY));
    assign gap_last     = (gap_cnt == GAP_W'(GAP_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = 2'b00;
        case (state)
            S_IDLE: begin
                if (bus.i_enable && bus.i_frame_pending && bus.i_tx_idle) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_START;
            S_START: begin
                if (!bus.i_tx_idle) begin
                    state_nxt = S_ACTIVE;
                end else if (timeout) begin
                    state_nxt = S_FAIL;
                    cause_nxt = 2'b10;
                end
            end
            S_ACTIVE: begin
                if (bus.i_tx_send_complete) begin
                    state_nxt = S_OK;
                end else if (rl_edge) begin
                    if (retry_at_max) begin
                        state_nxt = S_FAIL;
                        cause_nxt = 2'b01;
                    end
                end else if (bus.i_tx_idle) begin
                    state_nxt = arq_mode ? S_FAIL : S_OK;
                    cause_nxt = arq_mode ? 2'b11 : 2'b00;
                end else if (timeout) begin
                    state_nxt = S_FAIL;
                    cause_nxt = 2'b10;
                end
            end
            S_OK, S_FAIL: state_nxt = S_GAP;
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer       <= '0;
            gap_cnt     <= '0;
            retry_count <= '0;
            fail_cause  <= '0;
            good_frames <= '0;
            bad_frames  <= '0;
            arq_mode    <= 1'b0;
            rl_prev     <= 1'b0;
        end else begin
            rl_prev <= bus.i_tx_read_line;
            case (state)
                S_LAUNCH: begin
                    arq_mode    <= bus.i_arq_en;
                    retry_count <= '0;
                    timer       <= '0;
                    fail_cause  <= '0;
                end
                S_START: timer <= bus.i_tx_idle ? timer + 1'b1 : '0;
                S_ACTIVE: begin
                    if (!bus.i_tx_send_complete && rl_edge && !retry_at_max) begin
                        retry_count <= retry_count + 1'b1;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_OK: begin
                    gap_cnt <= '0;
                    if (good_frames != 16'hFFFF) good_frames <= good_frames + 1'b1;
                end
                S_FAIL: begin
                    gap_cnt <= '0;
                    if (bad_frames != 16'hFFFF) bad_frames <= bad_frames + 1'b1;
                end
                S_GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
            if (state_nxt == S_FAIL && state != S_FAIL) fail_cause <= cause_nxt;
        end
    end

    // Pulses decode directly from the state flop and are held low while reset is asserted.
    always_comb begin
        bus.o_frame_launch = (state == S_LAUNCH) && !i_rst;
        bus.o_frame_ok     = (state == S_OK)     && !i_rst;
        bus.o_frame_fail   = (state == S_FAIL)   && !i_rst;
        bus.o_tx_flush     = (state == S_FAIL)   && !i_rst;
        bus.o_busy         = (state != S_IDLE);
        bus.dbg_state      = state;
    end

    assign bus.o_fail_cause  = fail_cause;
    assign bus.o_retry_count = retry_count;
    assign bus.o_good_frames = good_frames;
    assign bus.o_bad_frames  = bad_frames;

endmodule

// File: tb/tb_arq_tx_scheduler.sv
// Self-checking bench for arq_tx_scheduler: directed frame scenarios driven at the falling edge,
// outcomes ({ok, fail, cause, retry}) predicted into a queue and matched by a monitor.
module tb_arq_tx_scheduler;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  arq_tx_scheduler_if bus ();

  arq_tx_scheduler #(
    .MAX_RETRY(4), .ACK_TIMEOUT_CYC(100), .GAP_CYC(16), .TMR_W(24)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int outcome_cnt = 0;
  int n_pushed = 0;
  int n_launch = 0;
  int out_cyc = 0;
  int launch_cyc = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard monitor
  logic prev_launch = 1'b0, prev_ok = 1'b0, prev_fail = 1'b0;
  always @(negedge clk) begin
    if (bus.o_frame_launch) n_launch++;
    if (bus.o_frame_launch && prev_launch) check_eq("launch_width", 1, 0);
    if (bus.o_frame_ok && prev_ok) check_eq("ok_width", 1, 0);
    if (bus.o_frame_fail && prev_fail) check_eq("fail_width", 1, 0);
    if (bus.o_frame_ok || bus.o_frame_fail || bus.o_tx_flush)
      check_eq("flush_with_fail", 40'(bus.o_tx_flush), 40'(bus.o_frame_fail));
    if (bus.o_frame_ok || bus.o_frame_fail) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_outcome", {bus.o_frame_ok, bus.o_frame_fail, bus.o_fail_cause, bus.o_retry_count}, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq("outcome", {bus.o_frame_ok, bus.o_frame_fail, bus.o_fail_cause, bus.o_retry_count}, 40'(e));
      end
      outcome_cnt++;
      out_cyc = cyc;
    end
    prev_launch = bus.o_frame_launch;
    prev_ok     = bus.o_frame_ok;
    prev_fail   = bus.o_frame_fail;
  end

  // driver tasks
  task automatic push_exp(input bit ok, input logic [1:0] cause, input logic [3:0] retry);
    exp_q.push_back({ok, ~ok, cause, retry});
    n_pushed++;
  endtask

  task automatic start_frame(input bit arq);
    bit seen;
    seen = 0;
    bus.i_arq_en = arq;
    bus.i_frame_pending = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_frame_launch) begin
        seen = 1;
        launch_cyc = cyc;
      end
    end
    if (!seen) check_eq("launch_timeout", 0, 1);
    bus.i_frame_pending = 1'b0;
  endtask

  task automatic idle_drop(input int n);
    repeat (n) @(negedge clk);
    bus.i_tx_idle = 1'b0;
  endtask

  task automatic replay();
    @(negedge clk) bus.i_tx_read_line = 1'b1;
    @(negedge clk) bus.i_tx_read_line = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_sc(input int wait_n);
    repeat (wait_n) @(negedge clk);
    bus.i_tx_send_complete = 1'b1;
    @(negedge clk) bus.i_tx_send_complete = 1'b0;
  endtask

  task automatic wait_outcome(input int budget);
    for (int i = 0; i < budget && outcome_cnt < n_pushed; i++) @(negedge clk);
    if (outcome_cnt < n_pushed) check_eq("outcome_timeout", 40'(outcome_cnt), 40'(n_pushed));
    bus.i_tx_idle = 1'b1;
    bus.i_tx_read_line = 1'b0;
    bus.i_tx_send_complete = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 100 && bus.o_busy; i++) @(negedge clk);
    check_eq("return_idle", 40'(bus.o_busy), 0);
  endtask

  initial begin
    bus.i_enable = 1'b0;
    bus.i_arq_en = 1'b1;
    bus.i_frame_pending = 1'b0;
    bus.i_tx_idle = 1'b1;
    bus.i_tx_send_complete = 1'b0;
    bus.i_tx_read_line = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 40'(bus.o_busy), 0);
    check_eq("rst_state", 40'(bus.dbg_state), 0);
    check_eq("rst_counters", {bus.o_good_frames, bus.o_bad_frames}, 0);
    check_eq("rst_cause_retry", {bus.o_fail_cause, bus.o_retry_count}, 0);

    // enable low blocks launch
    bus.i_frame_pending = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("enable_gate", 40'(n_launch), 0);
    bus.i_enable = 1'b1;

    // 1: ARQ on, good ACK
    push_exp(1, 2'b00, 4'd0);
    start_frame(1);
    idle_drop(2);
    pulse_sc(3);
    wait_outcome(50);
    check_eq("ok_latency", 40'(out_cyc - launch_cyc), 6);
    @(negedge clk);
    check_eq("good_after_1", {bus.o_good_frames, bus.o_bad_frames}, {16'd1, 16'd0});

    // 2: two replays then ACK; launch also measures the gap
    push_exp(1, 2'b00, 4'd2);
    start_frame(1);
    check_eq("gap_to_launch", 40'(launch_cyc - out_cyc), 18);
    idle_drop(2);
    replay();
    replay();
    pulse_sc(1);
    wait_outcome(50);
    @(negedge clk);
    check_eq("after_2", {bus.o_good_frames, bus.o_bad_frames, bus.o_retry_count}, {16'd2, 16'd0, 4'd2});

    // 3: retry limit on fifth edge
    push_exp(0, 2'b01, 4'd4);
    start_frame(1);
    idle_drop(2);
    for (int i = 0; i < 5; i++) replay();
    wait_outcome(50);
    @(negedge clk);
    check_eq("after_3", {bus.o_bad_frames, bus.o_fail_cause, bus.o_retry_count}, {16'd1, 2'b01, 4'd4});

    // 4a: timeout with idle never dropping
    push_exp(0, 2'b10, 4'd0);
    start_frame(1);
    wait_outcome(300);
    check_eq("timeout_start", 40'(out_cyc - launch_cyc), 101);
    // 4b: timeout counted from ACTIVE entry
    push_exp(0, 2'b10, 4'd0);
    start_frame(1);
    idle_drop(2);
    wait_outcome(300);
    check_eq("timeout_active", 40'(out_cyc - launch_cyc), 103);
    @(negedge clk);
    check_eq("bad_after_4", {bus.o_bad_frames, bus.o_fail_cause}, {16'd3, 2'b10});

    // 5: idle returns without ACK
    push_exp(1, 2'b00, 4'd0);
    start_frame(0);
    idle_drop(2);
    repeat (3) @(negedge clk);
    bus.i_tx_idle = 1'b1;
    wait_outcome(50);
    push_exp(0, 2'b11, 4'd0);
    start_frame(1);
    idle_drop(2);
    repeat (3) @(negedge clk);
    bus.i_tx_idle = 1'b1;
    wait_outcome(50);
    @(negedge clk);
    check_eq("after_5", {bus.o_good_frames, bus.o_bad_frames, bus.o_fail_cause}, {16'd3, 16'd4, 2'b11});

    // 6a: send_complete and replay edge together
    push_exp(1, 2'b00, 4'd1);
    start_frame(1);
    idle_drop(2);
    replay();
    bus.i_tx_send_complete = 1'b1;
    bus.i_tx_read_line = 1'b1;
    @(negedge clk);
    bus.i_tx_send_complete = 1'b0;
    bus.i_tx_read_line = 1'b0;
    wait_outcome(50);
    @(negedge clk);
    check_eq("simul_retry", {bus.o_good_frames, bus.o_retry_count}, {16'd4, 4'd1});
    wait_not_busy();

    // 6b: reset while ACTIVE
    start_frame(1);
    idle_drop(2);
    repeat (2) @(negedge clk);
    check_eq("pre_reset_active", 40'(bus.dbg_state), 3);
    rst = 1'b1;
    bus.i_tx_idle = 1'b1;
    @(negedge clk);
    check_eq("in_reset_pulses", {bus.o_frame_ok, bus.o_frame_fail, bus.o_tx_flush, bus.o_busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset", {bus.o_busy, bus.o_good_frames, bus.o_bad_frames, bus.o_retry_count}, 0);

    // 6c: good counter saturation
    force dut.good_frames = 16'hFFFF;
    @(negedge clk);
    release dut.good_frames;
    push_exp(1, 2'b00, 4'd0);
    start_frame(0);
    idle_drop(2);
    pulse_sc(2);
    wait_outcome(50);
    repeat (2) @(negedge clk);
    check_eq("good_saturate", {bus.o_good_frames, bus.o_bad_frames}, {16'hFFFF, 16'd0});

    repeat (5) @(negedge clk);
    check_eq("queue_drained", 40'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
